pipeline_stall_ctrl: RTL

- Consumes the `freez` request from the hazard detection unit, plus branch-taken and SRAM handshake status.
- Drives per-stage pipeline-register enables, flush and bubble controls for the 5-stage pipeline (IF/ID/EXE/MEM/WB).
- Owns the multi-cycle memory-wait state machine, a freeze watchdog, and optional stall performance counters.

---
 rtl/pipeline_stall_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_stall_ctrl : 5-stage pipeline stall/flush/bubble control with a
//                       memory-wait FSM, freeze watchdog and optional stall
//                       counters (enabled by defining STALL_PERF_EN).
// Revision: 1.0
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int FREEZE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freez,
    input  logic             Br_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    output logic             PC_en,
    output logic             IF_ID_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             EXE_MEM_en,
    output logic             MEM_WB_bubble,
    output logic             mem_busy,
    output logic             hazard_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int c_WD_W = $clog2(FREEZE_LIMIT + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(FREEZE_LIMIT);
    localparam logic [c_WD_W-1:0] c_WD_ARM = c_WD_W'(FREEZE_LIMIT - 1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_hazard_err;

    logic w_mem_stall;
    logic w_branch;
    logic w_freeze;

    // In MEM_WAIT the stall depends only on the SRAM; mem_req is not re-checked.
    assign w_mem_stall = rst && !sram_ready &&
                         ((r_state == ST_MEM_WAIT) || mem_req);
    assign w_branch    = rst && !w_mem_stall && Br_taken;
    assign w_freeze    = rst && !w_mem_stall && !Br_taken && freez;

    assign PC_en         = rst && !w_mem_stall && !w_freeze;
    assign IF_ID_en      = rst && !w_mem_stall && !w_freeze;
    assign EXE_MEM_en    = rst && !w_mem_stall;
    assign IF_ID_flush   = w_branch;
    assign ID_EX_bubble  = w_branch || w_freeze;
    assign MEM_WB_bubble = w_mem_stall;

    assign mem_busy   = (r_state == ST_MEM_WAIT);
    assign hazard_err = r_hazard_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_RUN;
            r_wd_cnt     <= '0;
            r_hazard_err <= 1'b0;
        end else begin
            r_state <= w_mem_stall ? ST_MEM_WAIT : ST_RUN;
            if (w_freeze) begin
                if (r_wd_cnt != c_WD_MAX) begin
                    r_wd_cnt <= r_wd_cnt + 1'b1;
                end
                // Flag rises on the edge where the run length reaches the limit.
                if (r_wd_cnt >= c_WD_ARM) begin
                    r_hazard_err <= 1'b1;
                end
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

`ifdef STALL_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_freeze_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles  <= '0;
            r_freeze_cycles <= '0;
            r_flush_count   <= '0;
        end else begin
            if ((w_mem_stall || w_freeze) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_freeze && (r_freeze_cycles != '1)) begin
                r_freeze_cycles <= r_freeze_cycles + 1'b1;
            end
            if (w_branch && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign freeze_cycles = r_freeze_cycles;
    assign flush_count   = r_flush_count;
`else
    assign stall_cycles  = '0;
    assign freeze_cycles = '0;
    assign flush_count   = '0;
`endif

endmodule
`default_nettype wire
